// File: rtl/puf_crp_sequencer.sv
// puf_crp_sequencer: drives the XOR arbiter PUF for one challenge/response pair per
// request. The challenge comes from chal_in or an internal LFSR and is held for the
// whole pair. The PUF is pulsed NVOTE times, and each response bit is majority-voted
// before the pair is offered on a valid/ready port.
module puf_crp_sequencer #(
    parameter int          CW         = 16,
    parameter int          RW         = 16,
    parameter int          PULSE_CYC  = 2,
    parameter int          SETTLE_CYC = 8,
    parameter int          NVOTE      = 5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode_ext,
    input  logic [CW-1:0] chal_in,
    output logic          busy,
    output logic          puf_pulse,
    output logic [CW-1:0] puf_challenge,
    input  logic [RW-1:0] puf_response,
    output logic          crp_valid,
    input  logic          crp_ready,
    output logic [CW-1:0] crp_challenge,
    output logic [RW-1:0] crp_response
);

    localparam int CNT_W = $clog2(NVOTE + 1);
    localparam int TMAX  = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int TW    = $clog2(TMAX + 1);

    localparam logic [CNT_W-1:0] HALF_VOTES  = CNT_W'(NVOTE / 2);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(NVOTE);
    localparam logic [TW-1:0]    PULSE_LOAD  = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0]    SETTLE_LOAD = TW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_PULSE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           state_reg;
    logic [TW-1:0]    timer_reg;
    logic [CNT_W-1:0] nsamp_reg;
    logic [CNT_W-1:0] nsamp_next;
    logic [15:0]      lfsr_reg;
    logic [15:0]      lfsr_next;
    logic [RW-1:0]    vote;
    logic             accept;

    // A request is taken only when idle; anything else on start is dropped.
    assign accept     = (state_reg == S_IDLE) && start;
    assign nsamp_next = nsamp_reg + 1'b1;

    // Fibonacci LFSR, taps 16/14/13/11. It never reaches zero from a nonzero seed.
    assign lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

    // Per-bit vote counters. The vote includes the sample being taken this cycle,
    // so the final SAMPLE cycle can register the result directly.
    generate
        for (genvar gi = 0; gi < RW; gi++) begin : g_vote
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;

            assign cnt_next = cnt_reg + CNT_W'(puf_response[gi]);
            assign vote[gi] = (cnt_next > HALF_VOTES);

            // Clear on an accepted request and add this bit's response on every sample.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (accept) begin
                    cnt_reg <= '0;
                end else if (state_reg == S_SAMPLE) begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    endgenerate

    // Sequencer FSM. All PUF-facing and consumer-facing outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            timer_reg     <= '0;
            nsamp_reg     <= '0;
            lfsr_reg      <= LFSR_SEED;
            busy          <= 1'b0;
            puf_pulse     <= 1'b0;
            puf_challenge <= '0;
            crp_valid     <= 1'b0;
            crp_challenge <= '0;
            crp_response  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        if (mode_ext) begin
                            puf_challenge <= chal_in;
                        end else begin
                            puf_challenge <= CW'(lfsr_reg);
                            lfsr_reg      <= lfsr_next;
                        end
                        nsamp_reg <= '0;
                        busy      <= 1'b1;
                        state_reg <= S_ARM;
                    end
                end
                S_ARM: begin
                    puf_pulse <= 1'b1;
                    timer_reg <= PULSE_LOAD;
                    state_reg <= S_PULSE;
                end
                S_PULSE: begin
                    if (timer_reg == '0) begin
                        puf_pulse <= 1'b0;
                        timer_reg <= SETTLE_LOAD;
                        state_reg <= S_SETTLE;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (timer_reg == '0) begin
                        state_reg <= S_SAMPLE;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end
                S_SAMPLE: begin
                    nsamp_reg <= nsamp_next;
                    if (nsamp_next == LAST_SAMPLE) begin
                        crp_valid     <= 1'b1;
                        crp_challenge <= puf_challenge;
                        crp_response  <= vote;
                        state_reg     <= S_DONE;
                    end else begin
                        state_reg <= S_ARM;
                    end
                end
                S_DONE: begin
                    if (crp_ready) begin
                        crp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    puf_pulse <= 1'b0;
                    crp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
